// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, PC step helper and default-width queue entry for the fetch stage.
package fetch_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;
  localparam int DEPTH_DEF = 4;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;
  function automatic int step_of(input int inst_w);
    return inst_w / 8;
  endfunction
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order queue of fetched {pc, inst} entries with synchronous flush.
module fetch_fifo #(
  parameter int DEPTH = fetch_pkg::DEPTH_DEF,
  parameter type entry_t = fetch_pkg::fetch_entry_t,
  parameter entry_t RST_ENTRY = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  entry_t                       din,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign head = mem[rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_ENTRY;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr] <= din;
      wr <= push ? wr + AW'(1) : wr;
      rd <= pop ? rd + AW'(1) : rd;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner issuing sequential prefetches and buffering returned instructions for decode.
module fetch_queue import fetch_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_next
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(step_of(INST_W));
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;
  localparam entry_t RST_E = '{pc: RESET_PC, inst: '0};
  logic [ADDR_W-1:0] req_pc, rsp_pc, aligned;
  logic [CW-1:0] outstanding, drop, count, out_nxt;
  logic acc, push, pop;
  entry_t head;
  // Credits cover both queued and in-flight entries, so a response always finds room.
  assign imem_req_valid = rst_n && ({1'b0, count} + {1'b0, outstanding} < (CW+1)'(DEPTH));
  assign imem_req_addr = req_pc;
  assign acc = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && drop == '0 && !redirect_valid;
  assign pop = out_valid && out_ready && !redirect_valid;
  assign out_nxt = outstanding + CW'(acc) - CW'(imem_rsp_valid);
  assign aligned = redirect_addr & ~(STEP - ADDR_W'(1));
  assign out_valid = count != '0;
  assign out_inst = head.inst;
  assign out_pc = head.pc;
  assign out_pc_next = head.pc + STEP;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
    end else begin
      outstanding <= out_nxt;
      req_pc <= redirect_valid ? aligned : acc ? req_pc + STEP : req_pc;
      rsp_pc <= redirect_valid ? aligned : push ? rsp_pc + STEP : rsp_pc;
      // Everything still in flight after a redirect belongs to the old path.
      drop <= redirect_valid ? out_nxt : (imem_rsp_valid && drop != '0) ? drop - CW'(1) : drop;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t), .RST_ENTRY(RST_E)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din('{pc: rsp_pc, inst: imem_rsp_data}),
    .head(head),
    .count(count)
  );
endmodule
